// File: rtl/countdown_pkg.sv
// Shared types and default sizing for the loadable countdown timer.
// Optional feature macro used by the timer: COUNTDOWN_AUTORELOAD_EN.
package countdown_pkg;

   localparam int unsigned CD_WIDTH    = 5;
   localparam int unsigned CD_PRESCALE = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/countdown_timer5bit_tick_prescaler.sv
// Divides the clock into decrement ticks; tick is combinational (_c) so the
// timer sees it in the same cycle the prescaler wraps.
module tick_prescaler
   import countdown_pkg::*;
#(
   parameter int unsigned PRESCALE = CD_PRESCALE
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick_c
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // Every enabled clock is a tick; no counter state exists.
         logic w_unused;
         assign w_unused = &{1'b0, clk, rstn, i_clr};
         assign o_tick_c = i_en;
      end else begin : g_cnt
         localparam int unsigned CW = $clog2(PRESCALE);
         localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

         logic [CW-1:0] r_cnt;
         logic          w_wrap;

         assign w_wrap   = (r_cnt == LAST);
         assign o_tick_c = i_en & w_wrap;

         always_ff @(posedge clk) begin
            if (rstn || i_clr) begin
               r_cnt <= '0;
            end else if (i_en) begin
               r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/countdown_timer5bit.sv
// Loadable down-counter with prescaled decrement and one-cycle done pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload the last loaded value at terminal count.
module countdown_timer5bit
   import countdown_pkg::*;
#(
   parameter int unsigned WIDTH    = CD_WIDTH,
   parameter int unsigned PRESCALE = CD_PRESCALE
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   state_e           r_state;
   logic [WIDTH-1:0] r_out;
   logic             r_busy;
   logic             r_done;

   logic             w_tick;
   logic             w_pre_clr;
   logic             w_pre_en;
   logic [WIDTH-1:0] w_eff_cnt;
   logic [WIDTH-1:0] w_reload;

   // Prescaler only advances in RUN while not paused; any host action restarts it.
   assign w_pre_en  = (r_state == ST_RUN) && !pause;
   assign w_pre_clr = (r_state != ST_RUN) || stop || load;
   assign w_eff_cnt = load ? load_val : r_out;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rstn     (rstn),
      .i_clr    (w_pre_clr),
      .i_en     (w_pre_en),
      .o_tick_c (w_tick)
   );

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] r_reload;

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_reload <= '0;
      end else if (load) begin
         r_reload <= load_val;
      end
   end

   assign w_reload = r_reload;
`else
   // Terminal count always lands on zero and drops back to IDLE.
   assign w_reload = '0;
`endif

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_out <= load_val;
               end
               if (start) begin
                  if (w_eff_cnt != '0) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (load) begin
                  r_out <= load_val;
                  if (load_val == '0) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else if (w_tick) begin
                  if (r_out == WIDTH'(1)) begin
                     // Zero reload value means a one-shot terminal.
                     r_done <= 1'b1;
                     r_out  <= w_reload;
                     if (w_reload == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_out <= r_out - WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_countdown_timer5bit.sv
// Directed bench for countdown_timer5bit: one instance at PRESCALE=1 and one at
// PRESCALE=3 share the same stimulus.
module tb_countdown_timer5bit;

`ifdef COUNTDOWN_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk;
   logic       rstn;
   logic       load;
   logic [4:0] load_val;
   logic       start;
   logic       stop;
   logic       pause;
   logic [4:0] out1, out3;
   logic       busy1, busy3;
   logic       done1, done3;

   int n_checks;
   int n_errors;

   countdown_timer5bit #(.WIDTH(5), .PRESCALE(1)) u_dut (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .pause(pause),
      .out(out1), .busy(busy1), .done(done1)
   );

   countdown_timer5bit #(.WIDTH(5), .PRESCALE(3)) u_dut_p3 (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .pause(pause),
      .out(out3), .busy(busy3), .done(done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 1'b1;
      step();
      rstn = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      rstn = 1'b1;
      step();
      step();
      rstn = 1'b0;

      // Reset state
      chk("rst_out", 32'(out1), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_out_p3", 32'(out3), 0);

      // Load 5 then start, PRESCALE=1
      load = 1'b1; load_val = 5'd5;
      step();
      load = 1'b0;
      chk("t1_load_out", 32'(out1), 5);
      chk("t1_load_busy", 32'(busy1), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_start_out", 32'(out1), 5);
      chk("t1_start_busy", 32'(busy1), 1);
      for (int k = 4; k >= 1; k--) begin
         step();
         chk("t1_count_out", 32'(out1), 32'(k));
         chk("t1_count_done", 32'(done1), 0);
      end
      step();
      chk("t1_term_out", 32'(out1), AR ? 5 : 0);
      chk("t1_term_done", 32'(done1), 1);
      chk("t1_term_busy", 32'(busy1), 32'(AR));
      step();
      chk("t1_done_once", 32'(done1), 0);

      // PRESCALE=3, load 2: out moves every third edge, done after six
      do_reset();
      load = 1'b1; load_val = 5'd2;
      step();
      load = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_start_out", 32'(out3), 2);
      chk("t2_start_busy", 32'(busy3), 1);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t2_out", 32'(out3), (k < 3) ? 2 : (k < 6) ? 1 : (AR ? 2 : 0));
         chk("t2_done", 32'(done3), (k == 6) ? 1 : 0);
      end
      chk("t2_term_busy", 32'(busy3), 32'(AR));

      // Load 31 with start in the same cycle, pause four cycles mid-count
      do_reset();
      load = 1'b1; load_val = 5'd31; start = 1'b1;
      step();
      load = 1'b0; start = 1'b0;
      chk("t3_start_out", 32'(out1), 31);
      chk("t3_start_busy", 32'(busy1), 1);
      step();
      step();
      chk("t3_pre_pause", 32'(out1), 29);
      pause = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t3_paused_out", 32'(out1), 29);
         chk("t3_paused_done", 32'(done1), 0);
      end
      pause = 1'b0;
      for (int k = 1; k <= 28; k++) begin
         step();
         chk("t3_count_out", 32'(out1), 32'(29 - k));
         chk("t3_count_done", 32'(done1), 0);
      end
      step();
      chk("t3_term_out", 32'(out1), AR ? 31 : 0);
      chk("t3_term_done", 32'(done1), 1);

      // Stop mid-run holds out, no done; restart resumes; reset mid-run clears
      do_reset();
      load = 1'b1; load_val = 5'd10; start = 1'b1;
      step();
      load = 1'b0; start = 1'b0;
      step(); step(); step();
      chk("t4_pre_stop", 32'(out1), 7);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_stop_out", 32'(out1), 7);
      chk("t4_stop_busy", 32'(busy1), 0);
      chk("t4_stop_done", 32'(done1), 0);
      step();
      chk("t4_held_out", 32'(out1), 7);
      chk("t4_held_done", 32'(done1), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_restart_busy", 32'(busy1), 1);
      step();
      chk("t4_resume_out", 32'(out1), 6);
      rstn = 1'b1;
      step();
      rstn = 1'b0;
      chk("t4_rst_out", 32'(out1), 0);
      chk("t4_rst_busy", 32'(busy1), 0);
      chk("t4_rst_done", 32'(done1), 0);
      step();
      chk("t4_post_rst_out", 32'(out1), 0);

      // Start with zero count, and load zero during RUN
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_zero_done", 32'(done1), 1);
      chk("t5_zero_busy", 32'(busy1), 0);
      step();
      chk("t5_zero_done_once", 32'(done1), 0);
      load = 1'b1; load_val = 5'd4; start = 1'b1;
      step();
      load = 1'b0; start = 1'b0;
      chk("t5_run_busy", 32'(busy1), 1);
      step();
      chk("t5_run_out", 32'(out1), 3);
      load = 1'b1; load_val = 5'd0;
      step();
      load = 1'b0;
      chk("t5_load0_out", 32'(out1), 0);
      chk("t5_load0_done", 32'(done1), 1);
      chk("t5_load0_busy", 32'(busy1), 0);
      step();
      chk("t5_load0_done_once", 32'(done1), 0);

      // Load in RUN restarts the prescaler (PRESCALE=3)
      do_reset();
      load = 1'b1; load_val = 5'd3; start = 1'b1;
      step();
      load = 1'b0; start = 1'b0;
      step();
      chk("t6_pre_load", 32'(out3), 3);
      load = 1'b1; load_val = 5'd2;
      step();
      load = 1'b0;
      chk("t6_load_out", 32'(out3), 2);
      chk("t6_load_busy", 32'(busy3), 1);
      step();
      chk("t6_hold1", 32'(out3), 2);
      step();
      chk("t6_hold2", 32'(out3), 2);
      step();
      chk("t6_tick", 32'(out3), 1);

`ifdef COUNTDOWN_AUTORELOAD_EN
      // Auto-reload: periodic done, stop ends it
      do_reset();
      load = 1'b1; load_val = 5'd3;
      step();
      load = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("t7_start_out", 32'(out1), 3);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t7_out", 32'(out1), (k % 3 == 0) ? 3 : 32'(3 - (k % 3)));
         chk("t7_done", 32'(done1), (k % 3 == 0) ? 1 : 0);
         chk("t7_busy", 32'(busy1), 1);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t7_stop_busy", 32'(busy1), 0);
      chk("t7_stop_out", 32'(out1), 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
